// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
//   Walks a (x, y) raster of H_TOTAL x V_TOTAL pixel positions, one step per
//   clk_pix edge with ce=1, and produces registered sync / enable / marker
//   outputs for the current position. A second counter pair runs LEAD steps
//   ahead so the framebuffer fetch path can issue reads early.
// Ports:
//   clk_pix, resetn (async, active-low), ce (pixel step enable)
//   x, y           current raster position
//   hsync, vsync   syncs, asserted level HS_POL / VS_POL
//   de             inside the active window
//   hblank, vblank outside the active columns / lines
//   line_start     x==0;  frame_start  x==0 and y==0
//   fetch_x/y/de   position and data-enable LEAD steps ahead
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 64,
  parameter int H_BACK   = 80,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 13,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int LEAD     = 4
) (
  input  logic          clk_pix,
  input  logic          resetn,
  input  logic          ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          hblank,
  output logic          vblank,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_de
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic          FDE0   = (LEAD < H_ACTIVE);

  generate
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
      $error("video_timing_gen: raster totals do not fit in CW bits");
    end
    if (LEAD < 0 || LEAD >= H_TOTAL) begin : g_bad_lead
      $error("video_timing_gen: LEAD must satisfy 0 <= LEAD < H_TOTAL");
    end
  endgenerate

  // Range test done in int so an end bound of exactly 2^CW is not truncated.
  function automatic logic in_win(input logic [CW-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  logic [CW-1:0] nx, ny, nfx, nfy;

  // Next positions for both counter pairs; flags are derived from these so
  // the registered flags line up with the registered coordinates.
  always_comb begin
    nx  = x + CW'(1);
    ny  = y;
    nfx = fetch_x + CW'(1);
    nfy = fetch_y;
    if (x == H_LAST) begin
      nx = '0;
      ny = (y == V_LAST) ? '0 : y + CW'(1);
    end
    if (fetch_x == H_LAST) begin
      nfx = '0;
      nfy = (fetch_y == V_LAST) ? '0 : fetch_y + CW'(1);
    end
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      x           <= '0;
      y           <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b1;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      fetch_x     <= CW'(LEAD);
      fetch_y     <= '0;
      fetch_de    <= FDE0;
    end else if (ce) begin
      x           <= nx;
      y           <= ny;
      hsync       <= in_win(nx, HS_START, HS_END) ? HS_POL : ~HS_POL;
      // ny only moves on the x wrap, so vsync switches on entry to x==0.
      vsync       <= in_win(ny, VS_START, VS_END) ? VS_POL : ~VS_POL;
      de          <= in_win(nx, 0, H_ACTIVE) && in_win(ny, 0, V_ACTIVE);
      hblank      <= !in_win(nx, 0, H_ACTIVE);
      vblank      <= !in_win(ny, 0, V_ACTIVE);
      line_start  <= (nx == '0);
      frame_start <= (nx == '0) && (ny == '0);
      fetch_x     <= nfx;
      fetch_y     <= nfy;
      fetch_de    <= in_win(nfx, 0, H_ACTIVE) && in_win(nfy, 0, V_ACTIVE);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: five instances (default mode, alternate
// 800x600 mode, a small 15x8 mode, a 16x8 mode filling CW=4 with LEAD=0, and
// the small mode with LEAD=H_TOTAL-1) share clock, reset and ce. A
// position-based model predicts every output of every instance each cycle;
// a table of hand-computed vectors walks the small mode through its corners.
module tb_video_timing_gen;

  logic clk_pix = 1'b0;
  logic resetn, ce;
  always #5 clk_pix = ~clk_pix;

  int n_cmp = 0, n_bad = 0, steps = 0;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int lead;
  } mode_t;

  typedef struct packed {
    int x, y;
    bit hs, vs, de, hb, vb, ls, fs;
    int fx, fy;
    bit fde;
  } obs_t;

  typedef struct {
    int    adv;
    obs_t  e;
    string nm;
  } vec_t;

  localparam mode_t M_DEF = '{640, 16, 64, 80, 480, 3, 4, 13, 1'b0, 1'b0, 4};
  localparam mode_t M_ALT = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 4};
  localparam mode_t M_SM  = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 4};
  localparam mode_t M_P2  = '{8, 2, 4, 2, 4, 1, 2, 1, 1'b0, 1'b0, 0};
  localparam mode_t M_LM  = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 14};

  logic [9:0]  d_x, d_y, d_fx, d_fy;
  logic [10:0] a_x, a_y, a_fx, a_fy;
  logic [3:0]  s_x, s_y, s_fx, s_fy, p_x, p_y, p_fx, p_fy, m_x, m_y, m_fx, m_fy;
  logic d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs, d_fde;
  logic a_hs, a_vs, a_de, a_hb, a_vb, a_ls, a_fs, a_fde;
  logic s_hs, s_vs, s_de, s_hb, s_vb, s_ls, s_fs, s_fde;
  logic p_hs, p_vs, p_de, p_hb, p_vb, p_ls, p_fs, p_fde;
  logic m_hs, m_vs, m_de, m_hb, m_vb, m_ls, m_fs, m_fde;

  video_timing_gen u_def (
    .clk_pix(clk_pix), .resetn(resetn), .ce(ce), .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
    .de(d_de), .hblank(d_hb), .vblank(d_vb), .line_start(d_ls), .frame_start(d_fs),
    .fetch_x(d_fx), .fetch_y(d_fy), .fetch_de(d_fde));

  video_timing_gen #(.H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_ACTIVE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23), .HS_POL(1'b1), .VS_POL(1'b1),
    .CW(11), .LEAD(4)) u_alt (
    .clk_pix(clk_pix), .resetn(resetn), .ce(ce), .x(a_x), .y(a_y), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .hblank(a_hb), .vblank(a_vb), .line_start(a_ls), .frame_start(a_fs),
    .fetch_x(a_fx), .fetch_y(a_fy), .fetch_de(a_fde));

  video_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CW(4), .LEAD(4)) u_sm (
    .clk_pix(clk_pix), .resetn(resetn), .ce(ce), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
    .de(s_de), .hblank(s_hb), .vblank(s_vb), .line_start(s_ls), .frame_start(s_fs),
    .fetch_x(s_fx), .fetch_y(s_fy), .fetch_de(s_fde));

  video_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CW(4), .LEAD(0)) u_p2 (
    .clk_pix(clk_pix), .resetn(resetn), .ce(ce), .x(p_x), .y(p_y), .hsync(p_hs), .vsync(p_vs),
    .de(p_de), .hblank(p_hb), .vblank(p_vb), .line_start(p_ls), .frame_start(p_fs),
    .fetch_x(p_fx), .fetch_y(p_fy), .fetch_de(p_fde));

  video_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CW(4), .LEAD(14)) u_lm (
    .clk_pix(clk_pix), .resetn(resetn), .ce(ce), .x(m_x), .y(m_y), .hsync(m_hs), .vsync(m_vs),
    .de(m_de), .hblank(m_hb), .vblank(m_vb), .line_start(m_ls), .frame_start(m_fs),
    .fetch_x(m_fx), .fetch_y(m_fy), .fetch_de(m_fde));

  function automatic obs_t mk(int x, int y, bit hs, bit vs, bit de, bit hb, bit vb,
                              bit ls, bit fs, int fx, int fy, bit fde);
    obs_t o;
    o.x = x; o.y = y; o.hs = hs; o.vs = vs; o.de = de; o.hb = hb; o.vb = vb;
    o.ls = ls; o.fs = fs; o.fx = fx; o.fy = fy; o.fde = fde;
    return o;
  endfunction

  // Expected outputs n steps after reset, from the linear raster index.
  function automatic obs_t exp_at(mode_t m, int n);
    int ht, vt, p, fp;
    obs_t o;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    p  = n % (ht * vt);
    fp = (p + m.lead) % (ht * vt);
    o.x  = p % ht;
    o.y  = p / ht;
    o.hs = (o.x >= m.ha + m.hf && o.x < m.ha + m.hf + m.hs) ? m.hp : !m.hp;
    o.vs = (o.y >= m.va + m.vf && o.y < m.va + m.vf + m.vs) ? m.vp : !m.vp;
    o.de = (o.x < m.ha) && (o.y < m.va);
    o.hb = (o.x >= m.ha);
    o.vb = (o.y >= m.va);
    o.ls = (o.x == 0);
    o.fs = (o.x == 0) && (o.y == 0);
    o.fx = fp % ht;
    o.fy = fp / ht;
    o.fde = (o.fx < m.ha) && (o.fy < m.va);
    return o;
  endfunction

  function automatic obs_t o_def();
    return mk(int'(d_x), int'(d_y), d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs, int'(d_fx), int'(d_fy), d_fde);
  endfunction
  function automatic obs_t o_alt();
    return mk(int'(a_x), int'(a_y), a_hs, a_vs, a_de, a_hb, a_vb, a_ls, a_fs, int'(a_fx), int'(a_fy), a_fde);
  endfunction
  function automatic obs_t o_sm();
    return mk(int'(s_x), int'(s_y), s_hs, s_vs, s_de, s_hb, s_vb, s_ls, s_fs, int'(s_fx), int'(s_fy), s_fde);
  endfunction
  function automatic obs_t o_p2();
    return mk(int'(p_x), int'(p_y), p_hs, p_vs, p_de, p_hb, p_vb, p_ls, p_fs, int'(p_fx), int'(p_fy), p_fde);
  endfunction
  function automatic obs_t o_lm();
    return mk(int'(m_x), int'(m_y), m_hs, m_vs, m_de, m_hb, m_vb, m_ls, m_fs, int'(m_fx), int'(m_fy), m_fde);
  endfunction

  task automatic cmp_obs(string tag, obs_t a, obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s step=%0d got x=%0d y=%0d hs%0b vs%0b de%0b hb%0b vb%0b ls%0b fs%0b fx=%0d fy=%0d fde%0b need x=%0d y=%0d hs%0b vs%0b de%0b hb%0b vb%0b ls%0b fs%0b fx=%0d fy=%0d fde%0b",
          tag, steps, a.x, a.y, a.hs, a.vs, a.de, a.hb, a.vb, a.ls, a.fs, a.fx, a.fy, a.fde,
          e.x, e.y, e.hs, e.vs, e.de, e.hb, e.vb, e.ls, e.fs, e.fx, e.fy, e.fde);
    end
  endtask

  task automatic cmp_int(string tag, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s got %0d need %0d", tag, a, e);
    end
  endtask

  task automatic check_all();
    cmp_obs("def", o_def(), exp_at(M_DEF, steps));
    cmp_obs("alt", o_alt(), exp_at(M_ALT, steps));
    cmp_obs("sm",  o_sm(),  exp_at(M_SM,  steps));
    cmp_obs("p2",  o_p2(),  exp_at(M_P2,  steps));
    cmp_obs("lm",  o_lm(),  exp_at(M_LM,  steps));
  endtask

  // One clk_pix cycle with the given ce; outputs checked on the falling edge.
  task automatic tick(bit c);
    ce = c;
    @(posedge clk_pix);
    if (c && resetn) steps++;
    @(negedge clk_pix);
    check_all();
  endtask

  vec_t tbl[14];
  int def_hs, def_de, def_ls, alt_hs, alt_de, sm_vs, sm_de, sm_hs, sm_fs;

  initial begin
    // Small mode (15x8, HS 10..12, VS 5..6, LEAD 4); adv = ce steps before the check.
    tbl[0]  = '{0,  mk(0, 0, 1,1,1,0,0,1,1, 4, 0, 1), "sm_origin"};
    tbl[1]  = '{1,  mk(1, 0, 1,1,1,0,0,0,0, 5, 0, 1), "sm_x1"};
    tbl[2]  = '{3,  mk(4, 0, 1,1,1,0,0,0,0, 8, 0, 0), "sm_fetch_hblank"};
    tbl[3]  = '{4,  mk(8, 0, 1,1,0,1,0,0,0, 12, 0, 0), "sm_hblank"};
    tbl[4]  = '{2,  mk(10, 0, 0,1,0,1,0,0,0, 14, 0, 0), "sm_hs_start"};
    tbl[5]  = '{1,  mk(11, 0, 0,1,0,1,0,0,0, 0, 1, 1), "sm_fetch_wrap"};
    tbl[6]  = '{2,  mk(13, 0, 1,1,0,1,0,0,0, 2, 1, 1), "sm_hs_end"};
    tbl[7]  = '{1,  mk(14, 0, 1,1,0,1,0,0,0, 3, 1, 1), "sm_line_last"};
    tbl[8]  = '{1,  mk(0, 1, 1,1,1,0,0,1,0, 4, 1, 1), "sm_line1"};
    tbl[9]  = '{60, mk(0, 5, 1,0,0,0,1,1,0, 4, 5, 0), "sm_vs_start"};
    tbl[10] = '{26, mk(11, 6, 0,0,0,1,1,0,0, 0, 7, 0), "sm_both_sync"};
    tbl[11] = '{15, mk(11, 7, 0,1,0,1,1,0,0, 0, 0, 1), "sm_fetch_frame_wrap"};
    tbl[12] = '{3,  mk(14, 7, 1,1,0,1,1,0,0, 3, 0, 1), "sm_frame_last"};
    tbl[13] = '{1,  mk(0, 0, 1,1,1,0,0,1,1, 4, 0, 1), "sm_frame_wrap"};

    resetn = 1'b0;
    ce     = 1'b0;
    repeat (3) @(negedge clk_pix);
    check_all();
    // ce high during reset must not move anything.
    ce = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    check_all();
    resetn = 1'b1;
    tick(1'b0);

    for (int i = 0; i < 14; i++) begin
      repeat (tbl[i].adv) tick(1'b1);
      cmp_obs(tbl[i].nm, o_sm(), tbl[i].e);
    end

    // Free run with ce=1 and pulse-width / per-period counts.
    def_hs = 0; def_de = 0; def_ls = 0; alt_hs = 0; alt_de = 0;
    sm_vs = 0; sm_de = 0; sm_hs = 0; sm_fs = 0;
    for (int i = 0; i < 2400; i++) begin
      tick(1'b1);
      if (steps >= 800 && steps < 1600) begin
        def_hs += int'(!d_hs); def_de += int'(d_de); def_ls += int'(d_ls);
      end
      if (steps >= 1056 && steps < 2112) begin
        alt_hs += int'(a_hs); alt_de += int'(a_de);
      end
      if (steps > 120 && steps <= 240) begin
        sm_vs += int'(!s_vs); sm_de += int'(s_de); sm_hs += int'(!s_hs); sm_fs += int'(s_fs);
      end
    end
    cmp_int("def_hsync_low_per_line", def_hs, 64);
    cmp_int("def_de_per_line", def_de, 640);
    cmp_int("def_line_start_per_line", def_ls, 1);
    cmp_int("alt_hsync_high_per_line", alt_hs, 128);
    cmp_int("alt_de_per_line", alt_de, 800);
    cmp_int("sm_vsync_low_per_frame", sm_vs, 30);
    cmp_int("sm_de_per_frame", sm_de, 32);
    cmp_int("sm_hsync_low_per_frame", sm_hs, 24);
    cmp_int("sm_frame_start_per_frame", sm_fs, 1);

    // ce every second cycle: one small frame spans 240 clk_pix cycles.
    sm_vs = 0; sm_hs = 0; sm_fs = 0;
    for (int i = 0; i < 240; i++) begin
      tick(i % 2 == 0);
      sm_vs += int'(!s_vs); sm_hs += int'(!s_hs); sm_fs += int'(s_fs);
    end
    cmp_int("half_ce_vsync_low_clks", sm_vs, 60);
    cmp_int("half_ce_hsync_low_clks", sm_hs, 48);
    cmp_int("half_ce_frame_start_clks", sm_fs, 2);

    // Mid-frame asynchronous reset between edges.
    repeat (37) tick(1'b1);
    #2 resetn = 1'b0;
    steps = 0;
    #1 check_all();
    ce = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    check_all();
    resetn = 1'b1;
    tick(1'b1);
    cmp_int("post_reset_def_x", int'(d_x), 1);
    cmp_int("post_reset_def_y", int'(d_y), 0);
    cmp_int("post_reset_sm_x", int'(s_x), 1);

    // Irregular ce pattern; the model tracks every step.
    for (int i = 0; i < 400; i++) tick(bit'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
